// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared mode encodings, pixel width and request-FSM state type
package rgb_pkg;

  localparam int PIX_W = 10;

  localparam logic [2:0] MODE_RGB  = 3'd0;
  localparam logic [2:0] MODE_R    = 3'd1;
  localparam logic [2:0] MODE_G    = 3'd2;
  localparam logic [2:0] MODE_B    = 3'd3;
  localparam logic [2:0] MODE_GRAY = 3'd4;
  localparam logic [2:0] MODE_AUTO = 3'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } req_state_t;

  // Modes 6 and 7 are reserved; everything up to auto-cycle is accepted.
  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_AUTO);
  endfunction

endpackage

// File: rtl/rgb_mode_mux.sv
// rtl/rgb_mode_mux.sv - registered channel-select / gray datapath, 1-cycle latency
module rgb_mode_mux
  import rgb_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic [2:0]       iMODE,
  input  logic [PIX_W-1:0] iRed,
  input  logic [PIX_W-1:0] iGreen,
  input  logic [PIX_W-1:0] iBlue,
  output logic             oDVAL,
  output logic [PIX_W-1:0] oDATA_R,
  output logic [PIX_W-1:0] oDATA_G,
  output logic [PIX_W-1:0] oDATA_B
);

  logic [PIX_W+1:0] w_sum;
  logic [PIX_W-1:0] w_gray;
  logic [PIX_W-1:0] w_r;
  logic [PIX_W-1:0] w_g;
  logic [PIX_W-1:0] w_b;

  // Select the channels for the requested mode; gray = (R + 2G + B) / 4 in a 12-bit sum.
  always_comb begin
    w_sum  = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    w_gray = w_sum[PIX_W+1:2];
    w_r    = '0;
    w_g    = '0;
    w_b    = '0;
    case (iMODE)
      MODE_RGB: begin
        w_r = iRed;
        w_g = iGreen;
        w_b = iBlue;
      end
      MODE_R:   w_r = iRed;
      MODE_G:   w_g = iGreen;
      MODE_B:   w_b = iBlue;
      MODE_GRAY: begin
        w_r = w_gray;
        w_g = w_gray;
        w_b = w_gray;
      end
      default: begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
      end
    endcase
  end

  // Register the selection; invalid pixels are forced to zero.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL   <= 1'b0;
      oDATA_R <= '0;
      oDATA_G <= '0;
      oDATA_B <= '0;
    end else begin
      oDVAL <= iDVAL;
      if (iDVAL) begin
        oDATA_R <= w_r;
        oDATA_G <= w_g;
        oDATA_B <= w_b;
      end else begin
        oDATA_R <= '0;
        oDATA_G <= '0;
        oDATA_B <= '0;
      end
    end
  end

endmodule

// File: rtl/rgb_channel_ctrl.sv
// rtl/rgb_channel_ctrl.sv - frame-synchronous mode controller with auto-cycle and pixel mux
module rgb_channel_ctrl
  import rgb_pkg::*;
#(
  parameter logic [2:0] DEFAULT_MODE    = 3'd1,
  parameter int          FRAMES_PER_STEP = 30,
  parameter int          CNT_W           = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iRed,
  input  logic [PIX_W-1:0] iGreen,
  input  logic [PIX_W-1:0] iBlue,
  input  logic [2:0]       iMODE,
  input  logic             iMODE_REQ,
  output logic             oMODE_ACK,
  output logic             oMODE_ERR,
  output logic             oBUSY,
  output logic [2:0]       oCUR_MODE,
  output logic             oDVAL,
  output logic [PIX_W-1:0] oDATA_R,
  output logic [PIX_W-1:0] oDATA_G,
  output logic [PIX_W-1:0] oDATA_B,
  output logic [CNT_W-1:0] oFRAME_CNT
);

  // Step counter is sized for the full legal FRAMES_PER_STEP range, independent of CNT_W.
  localparam int               STEP_W    = 16;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

  req_state_t        r_state;
  req_state_t        w_state_nxt;
  logic [2:0]        r_pend_mode;
  logic [2:0]        w_pend_nxt;
  logic [2:0]        r_cur_mode;
  logic              r_fval_d;
  logic              r_ack;
  logic              r_err;
  logic [1:0]        r_auto_idx;
  logic [1:0]        w_idx_nxt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] w_step_nxt;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic              w_fs;
  logic              w_req_ok;
  logic              w_req_err;
  logic              w_apply;
  logic [2:0]        w_new_mode;
  logic [2:0]        w_eff_mode;
  logic [2:0]        w_pix_mode;

  assign w_fs      = iFVAL & ~r_fval_d;
  assign w_req_ok  = iMODE_REQ & mode_legal(iMODE);
  assign w_req_err = iMODE_REQ & ~mode_legal(iMODE);

  // Request FSM: hold the latest legal request, apply it (or a same-cycle request) at frame start.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_mode;
    w_apply     = 1'b0;
    w_new_mode  = r_cur_mode;
    case (r_state)
      ST_IDLE: begin
        if (w_fs && w_req_ok) begin
          w_apply    = 1'b1;
          w_new_mode = iMODE;
        end else if (w_req_ok) begin
          w_pend_nxt  = iMODE;
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_fs) begin
          w_apply     = 1'b1;
          w_new_mode  = w_req_ok ? iMODE : r_pend_mode;
          w_state_nxt = ST_IDLE;
        end else if (w_req_ok) begin
          w_pend_nxt = iMODE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_eff_mode = w_apply ? w_new_mode : r_cur_mode;

  // Auto-cycle stepping: restart on entry to auto mode, otherwise count frames and rotate R->G->B.
  always_comb begin
    w_idx_nxt  = r_auto_idx;
    w_step_nxt = r_step_cnt;
    if (w_fs && (w_eff_mode == MODE_AUTO)) begin
      if (r_cur_mode != MODE_AUTO) begin
        w_idx_nxt  = 2'd0;
        w_step_nxt = '0;
      end else if (r_step_cnt == STEP_LAST) begin
        w_idx_nxt  = (r_auto_idx == 2'd2) ? 2'd0 : r_auto_idx + 2'd1;
        w_step_nxt = '0;
      end else begin
        w_step_nxt = r_step_cnt + STEP_W'(1);
      end
    end
  end

  // The first pixel of a frame already sees the freshly applied mode and auto index.
  assign w_pix_mode = (w_eff_mode == MODE_AUTO) ? (MODE_R + {1'b0, w_idx_nxt}) : w_eff_mode;

  // Controller state, pulses, auto-cycle counters and frame counter.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_pend_mode <= 3'd0;
      r_cur_mode  <= DEFAULT_MODE;
      r_fval_d    <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_auto_idx  <= 2'd0;
      r_step_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_mode <= w_pend_nxt;
      r_fval_d    <= iFVAL;
      r_ack       <= w_apply;
      r_err       <= w_req_err;
      r_auto_idx  <= w_idx_nxt;
      r_step_cnt  <= w_step_nxt;
      if (w_apply) begin
        r_cur_mode <= w_new_mode;
      end
      if (w_fs) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign oMODE_ACK  = r_ack;
  assign oMODE_ERR  = r_err;
  assign oBUSY      = (r_state == ST_PENDING);
  assign oCUR_MODE  = r_cur_mode;
  assign oFRAME_CNT = r_frame_cnt;

  rgb_mode_mux u_mux (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDVAL   (iDVAL),
    .iMODE   (w_pix_mode),
    .iRed    (iRed),
    .iGreen  (iGreen),
    .iBlue   (iBlue),
    .oDVAL   (oDVAL),
    .oDATA_R (oDATA_R),
    .oDATA_G (oDATA_G),
    .oDATA_B (oDATA_B)
  );

endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// tb/tb_rgb_channel_ctrl.sv - directed table plus randomized model check of rgb_channel_ctrl
module tb_rgb_channel_ctrl;

  localparam int FPS = 2;
  localparam logic [9:0] RR  = 10'h3FF;
  localparam logic [9:0] GG  = 10'h155;
  localparam logic [9:0] BB  = 10'h0AA;
  localparam logic [9:0] GRY = 10'h1D4;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iFVAL = 1'b0;
  logic       iDVAL = 1'b0;
  logic [9:0] iRed = '0;
  logic [9:0] iGreen = '0;
  logic [9:0] iBlue = '0;
  logic [2:0] iMODE = '0;
  logic       iMODE_REQ = 1'b0;

  logic        oMODE_ACK, oMODE_ERR, oBUSY, oDVAL;
  logic [2:0]  oCUR_MODE;
  logic [9:0]  oDATA_R, oDATA_G, oDATA_B;
  logic [15:0] oFRAME_CNT;

  logic        s_ack, s_err, s_busy, s_dval;
  logic [2:0]  s_cur;
  logic [9:0]  s_r, s_g, s_b;
  logic [2:0]  s_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iCLK = ~iCLK;

  rgb_channel_ctrl #(.DEFAULT_MODE(3'd1), .FRAMES_PER_STEP(FPS), .CNT_W(16)) u_dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iMODE(iMODE), .iMODE_REQ(iMODE_REQ),
    .oMODE_ACK(oMODE_ACK), .oMODE_ERR(oMODE_ERR), .oBUSY(oBUSY), .oCUR_MODE(oCUR_MODE),
    .oDVAL(oDVAL), .oDATA_R(oDATA_R), .oDATA_G(oDATA_G), .oDATA_B(oDATA_B),
    .oFRAME_CNT(oFRAME_CNT)
  );

  // Narrow-counter instance so the frame-counter wrap is reached in a short run.
  rgb_channel_ctrl #(.DEFAULT_MODE(3'd1), .FRAMES_PER_STEP(FPS), .CNT_W(3)) u_dut_small (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iMODE(iMODE), .iMODE_REQ(iMODE_REQ),
    .oMODE_ACK(s_ack), .oMODE_ERR(s_err), .oBUSY(s_busy), .oCUR_MODE(s_cur),
    .oDVAL(s_dval), .oDATA_R(s_r), .oDATA_G(s_g), .oDATA_B(s_b),
    .oFRAME_CNT(s_fcnt)
  );

  // Reference model state
  int m_fval_d, m_cur, m_pend, m_idx, m_step, m_fcnt;
  int e_ack, e_err, e_busy, e_dval, e_r, e_g, e_b;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fval_d = 0; m_cur = 1; m_pend = -1; m_idx = 0; m_step = 0; m_fcnt = 0;
    e_ack = 0; e_err = 0; e_busy = 0; e_dval = 0; e_r = 0; e_g = 0; e_b = 0;
  endtask

  task automatic model_step(input int rst, input int fval, input int dval,
                            input int r, input int g, input int b, input int mode, input int req);
    int fs, legal, newm, chan, gray;
    bit entering;
    if (rst != 0) begin
      model_reset();
      return;
    end
    fs    = (fval != 0 && m_fval_d == 0) ? 1 : 0;
    legal = (mode <= 5) ? 1 : 0;
    e_err = (req != 0 && legal == 0) ? 1 : 0;
    e_ack = 0;
    if (fs != 0) begin
      newm = (req != 0 && legal != 0) ? mode : m_pend;
      entering = 1'b0;
      if (newm >= 0) begin
        e_ack    = 1;
        entering = (newm == 5 && m_cur != 5);
        m_cur    = newm;
      end
      m_pend = -1;
      if (m_cur == 5) begin
        if (entering) begin
          m_idx = 0; m_step = 0;
        end else if (m_step == FPS - 1) begin
          m_idx = (m_idx + 1) % 3; m_step = 0;
        end else begin
          m_step++;
        end
      end
      m_fcnt = (m_fcnt + 1) % 65536;
    end else if (req != 0 && legal != 0) begin
      m_pend = mode;
    end
    m_fval_d = fval;
    e_busy = (m_pend >= 0) ? 1 : 0;
    e_dval = dval;
    chan = (m_cur == 5) ? 1 + m_idx : m_cur;
    gray = (r + 2 * g + b) / 4;
    e_r = 0; e_g = 0; e_b = 0;
    if (dval != 0) begin
      case (chan)
        0: begin e_r = r; e_g = g; e_b = b; end
        1: e_r = r;
        2: e_g = g;
        3: e_b = b;
        4: begin e_r = gray; e_g = gray; e_b = gray; end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic rst, input logic fval, input logic dval,
                       input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                       input logic [2:0] mode, input logic req);
    iRST = rst; iFVAL = fval; iDVAL = dval; iRed = r; iGreen = g; iBlue = b;
    iMODE = mode; iMODE_REQ = req;
    @(posedge iCLK);
    #1;
    model_step(int'(rst), int'(fval), int'(dval), int'(r), int'(g), int'(b), int'(mode), int'(req));
    check("m_ack",  int'(oMODE_ACK), e_ack);
    check("m_err",  int'(oMODE_ERR), e_err);
    check("m_busy", int'(oBUSY), e_busy);
    check("m_cur",  int'(oCUR_MODE), m_cur);
    check("m_dval", int'(oDVAL), e_dval);
    check("m_r",    int'(oDATA_R), e_r);
    check("m_g",    int'(oDATA_G), e_g);
    check("m_b",    int'(oDATA_B), e_b);
    check("m_fcnt", int'(oFRAME_CNT), m_fcnt);
    check("m_fcnt3", int'(s_fcnt), m_fcnt % 8);
    check("m_cur3",  int'(s_cur), m_cur);
  endtask

  typedef struct {
    logic       rst, fval, dval;
    logic [2:0] mode;
    logic       req;
    logic [2:0] e_cur;
    logic       e_busy, e_ack, e_err;
    logic [9:0] e_r, e_g, e_b;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic fval, input logic dval,
                             input logic [2:0] mode, input logic req,
                             input logic [2:0] cur, input logic busy, input logic ack, input logic err,
                             input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vec_t t;
    t.rst = rst; t.fval = fval; t.dval = dval; t.mode = mode; t.req = req;
    t.e_cur = cur; t.e_busy = busy; t.e_ack = ack; t.e_err = err;
    t.e_r = r; t.e_g = g; t.e_b = b;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int fcnt_before;
    logic fv;

    // Directed vectors: rst fval dval mode req | cur busy ack err | R G B
    tbl.push_back(v(0,1,1,0,0, 1,0,0,0, RR,0,0));     // 0 first frame, mode R
    tbl.push_back(v(0,1,1,4,1, 1,1,0,0, RR,0,0));     // 1 request gray mid-frame
    tbl.push_back(v(0,1,1,0,0, 1,1,0,0, RR,0,0));     // 2
    tbl.push_back(v(0,0,0,0,0, 1,1,0,0, 0,0,0));      // 3 blanking
    tbl.push_back(v(0,1,1,0,0, 4,0,1,0, GRY,GRY,GRY));// 4 gray at fs
    tbl.push_back(v(0,1,1,2,1, 4,1,0,0, GRY,GRY,GRY));// 5 request 2
    tbl.push_back(v(0,1,0,3,1, 4,1,0,0, 0,0,0));      // 6 request 3 overwrites
    tbl.push_back(v(0,0,0,0,0, 4,1,0,0, 0,0,0));      // 7
    tbl.push_back(v(0,1,1,0,0, 3,0,1,0, 0,0,BB));     // 8 single ack, mode 3
    tbl.push_back(v(0,1,1,6,1, 3,0,0,1, 0,0,BB));     // 9 reserved -> err
    tbl.push_back(v(0,1,1,2,1, 3,1,0,0, 0,0,BB));     // 10 pending 2
    tbl.push_back(v(0,1,1,7,1, 3,1,0,1, 0,0,BB));     // 11 reserved keeps pending
    tbl.push_back(v(0,0,0,0,0, 3,1,0,0, 0,0,0));      // 12
    tbl.push_back(v(0,1,1,0,1, 0,0,1,0, RR,GG,BB));   // 13 bypass at fs overrides 2
    tbl.push_back(v(0,1,1,0,0, 0,0,0,0, RR,GG,BB));   // 14
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0,0));      // 15
    tbl.push_back(v(0,1,1,5,1, 5,0,1,0, RR,0,0));     // 16 auto entry, frame 1 R
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 17
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, RR,0,0));     // 18 frame 2 R
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 19
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, 0,GG,0));     // 20 frame 3 G
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 21
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, 0,GG,0));     // 22 frame 4 G
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 23
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, 0,0,BB));     // 24 frame 5 B
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 25
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, 0,0,BB));     // 26 frame 6 B
    tbl.push_back(v(0,0,0,0,0, 5,0,0,0, 0,0,0));      // 27
    tbl.push_back(v(0,1,1,0,0, 5,0,0,0, RR,0,0));     // 28 frame 7 R
    tbl.push_back(v(0,1,1,2,1, 5,1,0,0, RR,0,0));     // 29 pending mid-frame
    tbl.push_back(v(1,1,1,0,0, 1,0,0,0, 0,0,0));      // 30 reset discards it
    tbl.push_back(v(0,1,1,0,0, 1,0,0,0, RR,0,0));     // 31 fs after reset, no ack
    tbl.push_back(v(0,1,1,0,0, 1,0,0,0, RR,0,0));     // 32

    model_reset();
    drive(1, 0, 0, '0, '0, '0, 3'd0, 0);
    drive(1, 0, 0, '0, '0, '0, 3'd0, 0);
    check("rst_cur",  int'(oCUR_MODE), 1);
    check("rst_busy", int'(oBUSY), 0);
    check("rst_ack",  int'(oMODE_ACK), 0);
    check("rst_dval", int'(oDVAL), 0);
    check("rst_fcnt", int'(oFRAME_CNT), 0);

    fcnt_before = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fval, tbl[i].dval, RR, GG, BB, tbl[i].mode, tbl[i].req);
      check($sformatf("v%0d_cur", i),  int'(oCUR_MODE), int'(tbl[i].e_cur));
      check($sformatf("v%0d_busy", i), int'(oBUSY), int'(tbl[i].e_busy));
      check($sformatf("v%0d_ack", i),  int'(oMODE_ACK), int'(tbl[i].e_ack));
      check($sformatf("v%0d_err", i),  int'(oMODE_ERR), int'(tbl[i].e_err));
      check($sformatf("v%0d_dval", i), int'(oDVAL), tbl[i].rst ? 0 : int'(tbl[i].dval));
      check($sformatf("v%0d_r", i),    int'(oDATA_R), int'(tbl[i].e_r));
      check($sformatf("v%0d_g", i),    int'(oDATA_G), int'(tbl[i].e_g));
      check($sformatf("v%0d_b", i),    int'(oDATA_B), int'(tbl[i].e_b));
      if (i == 15) fcnt_before = int'(oFRAME_CNT);
      if (i == 28) check("auto_fcnt_delta", int'(oFRAME_CNT) - fcnt_before, 7);
    end

    // Hold iFVAL low with a request: it must stay pending with no ack.
    drive(0, 0, 0, RR, GG, BB, 3'd2, 1);
    for (int k = 0; k < 20; k++) drive(0, 0, 0, RR, GG, BB, 3'd0, 0);
    check("hold_busy", int'(oBUSY), 1);
    check("hold_cur",  int'(oCUR_MODE), 1);
    drive(0, 1, 1, RR, GG, BB, 3'd0, 0);
    check("hold_ack",  int'(oMODE_ACK), 1);
    check("hold_g",    int'(oDATA_G), int'(GG));

    // Randomized traffic checked against the reference model.
    fv = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      logic rst, req;
      if ($urandom_range(0, 3) == 0) fv = ~fv;
      rst = ($urandom_range(0, 399) == 0);
      req = ($urandom_range(0, 5) == 0);
      drive(rst, fv, 1'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
            3'($urandom_range(0, 7)), req);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
